// File: rtl/count_enable_ctrl.sv
// rtl/count_enable_ctrl.sv - run/stop/single-step cnt_en pulse generator with prescaler and pulse tally
module count_enable_ctrl #(
  parameter int DIV   = 4,
  parameter int PRE_W = 8
) (
  input  logic       clock,
  input  logic       clear,
  input  logic       start,
  input  logic       stop,
  input  logic       step,
  output logic       cnt_en,
  output logic       running,
  output logic [7:0] pulse_count
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  // Terminal prescaler value; DIV=2^PRE_W still fits because only DIV-1 is stored.
  localparam logic [PRE_W-1:0] DIV_M1 = PRE_W'(DIV - 1);

  logic [0:0]       state_q, state_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic             cnt_en_q, cnt_en_d;
  logic             running_q, running_d;
  logic [7:0]       pulse_count_q, pulse_count_d;

  // Next-state logic: stop beats start/step everywhere; start/step are ignored in RUN.
  always_comb begin
    state_d       = state_q;
    pre_d         = pre_q;
    cnt_en_d      = 1'b0;
    pulse_count_d = pulse_count_q;
    case (state_q)
      IDLE: begin
        if (stop) begin
          state_d = IDLE;
        end else if (start) begin
          state_d = RUN;
          pre_d   = '0;
        end else if (step) begin
          cnt_en_d = 1'b1;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
          pre_d   = '0;
        end else if (pre_q == DIV_M1) begin
          pre_d    = '0;
          cnt_en_d = 1'b1;
        end else begin
          pre_d = pre_q + PRE_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        pre_d   = '0;
      end
    endcase
    running_d = (state_d == RUN);
    // Tally saturates at 255 so a long run never aliases back to a small count.
    if (cnt_en_d && (pulse_count_q != 8'hFF)) begin
      pulse_count_d = pulse_count_q + 8'd1;
    end
  end

  // State registers with synchronous clear dominating all requests.
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q       <= IDLE;
      pre_q         <= '0;
      cnt_en_q      <= 1'b0;
      running_q     <= 1'b0;
      pulse_count_q <= 8'd0;
    end else begin
      state_q       <= state_d;
      pre_q         <= pre_d;
      cnt_en_q      <= cnt_en_d;
      running_q     <= running_d;
      pulse_count_q <= pulse_count_d;
    end
  end

  assign cnt_en      = cnt_en_q;
  assign running     = running_q;
  assign pulse_count = pulse_count_q;

endmodule

// File: doc/count_enable_ctrl.md
# count_enable_ctrl

Run/stop/single-step controller that generates the `cnt_en` pulse stream for the 4-bit synchronous counter. Sits directly upstream of the counter: its `cnt_en` output drives the counter's `cnt_en` input, and both blocks share `clock`. A programmable prescaler sets the pulse rate; a pulse tally lets the bench or the system check how many counts were requested.

## Interface
- `DIV`, 4, prescaler divide ratio; one `cnt_en` pulse every `DIV` clocks while running. Legal range 1..2^`PRE_W`.
- `PRE_W`, 8, prescaler register width.
- `clock`  input  1  system clock; all state updates on the rising edge.
- `clear`  input  1  reset. One clock; reset is synchronous and active-high. Dominates every other input.
- `start`  input  1  level-sampled each edge; requests RUN.
- `stop`  input  1  level-sampled each edge; requests IDLE.
- `step`  input  1  level-sampled each edge; requests one `cnt_en` pulse while IDLE.
- `cnt_en`  output  1  registered; high for exactly one clock per issued count.
- `running`  output  1  registered; high while state is RUN.
- `pulse_count`  output  8  registered; number of `cnt_en` pulses issued since `clear`, saturating.

## Operation
- States: IDLE, RUN. Reset state is IDLE.
- Reset values, forced on any edge with `clear`=1: state IDLE, prescaler 0, `cnt_en` 0, `running` 0, `pulse_count` 0.
- IDLE, `stop`=1: stay in IDLE. `cnt_en` is 0.
- IDLE, `start`=1 and `stop`=0: go to RUN, prescaler <= 0, `cnt_en` <= 0.
- IDLE, `step`=1 with `start`=0 and `stop`=0: stay in IDLE, `cnt_en` <= 1 for one clock.
- IDLE, `step` held high: one pulse per clock. Each clock is an independent request.
- IDLE, no request: `cnt_en` <= 0.
- RUN, `stop`=1: go to IDLE, prescaler <= 0, `cnt_en` <= 0. `stop` wins over `start` and `step` in every state.
- RUN, no `stop`, prescaler == `DIV`-1: prescaler <= 0, `cnt_en` <= 1.
- RUN, no `stop`, any other prescaler value: prescaler += 1, `cnt_en` <= 0.
- RUN, `start` or `step`: ignored; the prescaler does not restart.
- `pulse_count` increments on every edge that loads `cnt_en` <= 1. It holds at 255 (8'hFF) and never wraps.
- `running` <= 1 exactly on the edges that leave or keep the state in RUN.

## Timing
- `start` accepted at edge E0: `running`=1 after E0. The first `cnt_en` is high in the cycle after edge E0+`DIV`. Subsequent pulses are spaced exactly `DIV` clocks apart.
- `DIV`=1: `cnt_en` is high every cycle starting after E1.
- `step` accepted at edge E: `cnt_en` is high from E to E+1 (one-cycle latency).
- `stop` at edge E: `cnt_en`=0 and `running`=0 after E. Any pulse due at E is suppressed and not counted.
- `clear` mid-RUN: the next edge produces full reset values. The pending prescaler phase is discarded.
- `pulse_count` updates on the same edge that raises `cnt_en`.

## Test plan
- Reset: hold `clear`=1 for 3 clocks with `start`=1 -> `cnt_en`=0, `running`=0, `pulse_count`=0 throughout.
- Run, `DIV`=4: pulse `start` for 1 clock, then wait 40 clocks -> `cnt_en` high on clocks 4, 8, ..., 40 after acceptance; `pulse_count`=10; downstream counter `q` reads 4'hA.
- Single step: in IDLE, drive `step`=1 for 3 clocks -> 3 consecutive `cnt_en` pulses and `pulse_count`=3. Then drive `step` during RUN -> no extra pulse and no prescaler reset.
- Stop priority: `start`=`stop`=1 in IDLE -> remain IDLE. In RUN, assert `stop` on the edge where prescaler=3 -> no pulse, `running`=0, count unchanged.
- Saturation: `DIV`=1, run 300 clocks -> `pulse_count` reaches 255 and stays 255 while `cnt_en` keeps pulsing.
- `clear` mid-RUN (prescaler=2): one clock of `clear`, then `start` -> first pulse exactly `DIV` clocks after the new acceptance; `pulse_count` restarts from 0.
